// File: rtl/gpioemu_pkg.sv
// gpioemu_pkg
//   Shared definitions for the gpioemu multiply + popcount peripheral:
//   bus register addresses, STATUS bit positions and the control FSM states.
//   Optional feature macro used by the top: GPIOEMU_MULPOP_SAT_EN.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam int ST_VALID = 0;
  localparam int ST_READY = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_IGN   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MULT  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/gpioemu_shiftadd_mul.sv
// gpioemu_shiftadd_mul
//   Sequential shift-add multiplier, one multiplier bit per clock.
//   Ports:
//     clk, n_reset  clock, asynchronous active-low reset
//     i_start       load operands and clear the accumulator (ignored state-wise while busy
//                   only because the top never pulses it then)
//     i_a, i_b      operands (OP_W bits)
//     o_busy        high while accumulating
//     o_done        one-cycle pulse on the cycle after the last partial product is added
//     o_product     2*OP_W-bit accumulator, never truncated
//   Handshake: i_start is a single-cycle request; o_busy rises the cycle after it and stays
//   high for exactly OP_W cycles; o_done pulses once as o_busy falls and o_product is then
//   stable until the next i_start.
module gpioemu_shiftadd_mul #(
  parameter int OP_W = 24
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 i_start,
  input  logic [OP_W-1:0]      i_a,
  input  logic [OP_W-1:0]      i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*OP_W-1:0]    o_product
);

  localparam int PW = 2 * OP_W;
  localparam int CW = $clog2(OP_W);

  logic [PW-1:0]   r_a;
  logic [PW-1:0]   r_acc;
  logic [OP_W-1:0] r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a    <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_a    <= PW'(i_a);
        r_b    <= i_b;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        // r_a holds A1 << i and r_b[0] holds A2[i] for the current bit i
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(OP_W - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/gpioemu_mulpop.sv
// gpioemu_mulpop
//   Bus-mapped multiply + popcount accelerator. The host writes A1/A2 shadow registers,
//   starts with a CTRL write, then reads W (product), L (popcount of W) and STATUS.
//   Optional feature macro: GPIOEMU_MULPOP_SAT_EN (saturate W/L on overflow).
//   Ports:
//     clk, n_reset     clock, asynchronous active-low reset
//     saddress         bus address
//     srd, swr         read / write strobes, sampled on posedge clk
//     sdata_in         write data
//     sdata_out        registered read data, held between reads
//     gpio_in          general-purpose inputs
//     gpio_latch       capture enable for gpio_in
//     gpio_out         {zero, completed-operation counter}
//     gpio_in_s_insp   captured gpio_in
//     o_dbg_state      current control FSM state
module gpioemu_mulpop
  import gpioemu_pkg::*;
#(
  parameter int OP_W  = 24,
  parameter int RES_W = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp,
  output state_t      o_dbg_state
);

  localparam int PW    = 2 * OP_W;
  localparam int LW    = $clog2(RES_W + 1);
  localparam int EXT_W = (PW > RES_W) ? PW : RES_W;

  state_t             r_state;
  logic [OP_W-1:0]    r_a1_sh;
  logic [OP_W-1:0]    r_a2_sh;
  logic [RES_W-1:0]   r_w;
  logic [LW-1:0]      r_l;
  logic               r_valid;
  logic               r_ready;
  logic               r_done;
  logic               r_ign;
  logic [CNT_W-1:0]   r_op_count;
  logic [31:0]        r_sdata_out;
  logic [31:0]        r_gpio_in;

  logic               w_ctrl_wr;
  logic               w_can_start;
  logic               w_start;
  logic               w_status_rd;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [PW-1:0]      w_prod;
  logic [EXT_W-1:0]   w_prod_ext;
  logic [RES_W-1:0]   w_trunc;
  logic               w_ovf;
  logic [LW-1:0]      w_pop_trunc;
  logic [RES_W-1:0]   w_res;
  logic [LW-1:0]      w_pop;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;
  logic               w_unused_ok;

  assign w_ctrl_wr   = swr && (saddress == ADDR_CTRL);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start     = w_ctrl_wr && w_can_start;
  assign w_status_rd = srd && (saddress == ADDR_CTRL);
  assign w_unused_ok = &{1'b0, sdata_in};

  // Operands are taken straight from the shadows on the start edge, so a shadow write
  // on that same edge only affects the following operation.
  gpioemu_shiftadd_mul #(.OP_W(OP_W)) u_mul (
    .clk       (clk),
    .n_reset   (n_reset),
    .i_start   (w_start),
    .i_a       (r_a1_sh),
    .i_b       (r_a2_sh),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // Result shaping: overflow is any product bit at or above RES_W.
  always_comb begin
    w_prod_ext  = EXT_W'(w_prod);
    w_trunc     = w_prod_ext[RES_W-1:0];
    w_ovf       = |(w_prod >> RES_W);
    w_pop_trunc = '0;
    for (int i = 0; i < RES_W; i++) w_pop_trunc = w_pop_trunc + LW'(w_trunc[i]);
`ifdef GPIOEMU_MULPOP_SAT_EN
    w_res = w_ovf ? '1 : w_trunc;
    w_pop = w_ovf ? LW'(RES_W) : w_pop_trunc;
`else
    w_res = w_trunc;
    w_pop = w_pop_trunc;
`endif
  end

  always_comb begin
    w_status           = '0;
    w_status[ST_VALID] = r_valid;
    w_status[ST_READY] = r_ready;
    w_status[ST_DONE]  = r_done;
    w_status[ST_IGN]   = r_ign;
  end

  always_comb begin
    w_rdata = '0;
    case (saddress)
      ADDR_W:    w_rdata = 32'(r_w);
      ADDR_L:    w_rdata = 32'(r_l);
      ADDR_CTRL: w_rdata = w_status;
      default:   w_rdata = '0;
    endcase
  end

  // Control FSM plus everything it owns: results, STATUS flags, op counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_l        <= '0;
      r_valid    <= 1'b1;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_ign      <= 1'b0;
      r_op_count <= '0;
    end else begin
      // A rejected start on the same edge as a STATUS read stays set: the read
      // returned the old value, so the event has not been reported yet.
      if (w_ctrl_wr && !w_can_start) r_ign <= 1'b1;
      else if (w_status_rd)          r_ign <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_ctrl_wr) begin
            r_state <= S_LOAD;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD:  r_state <= S_MULT;
        S_MULT:  if (w_mul_done && !w_mul_busy) r_state <= S_COUNT;
        S_COUNT: begin
          r_w        <= w_res;
          r_l        <= w_pop;
          r_valid    <= ~w_ovf;
          r_ready    <= 1'b1;
          r_done     <= 1'b1;
          r_op_count <= r_op_count + CNT_W'(1);
          r_state    <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a1_sh <= '0;
      r_a2_sh <= '0;
    end else if (swr) begin
      if (saddress == ADDR_A1) r_a1_sh <= sdata_in[OP_W-1:0];
      if (saddress == ADDR_A2) r_a2_sh <= sdata_in[OP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)  r_sdata_out <= '0;
    else if (srd)  r_sdata_out <= w_rdata;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)        r_gpio_in <= '0;
    else if (gpio_latch) r_gpio_in <= gpio_in;
  end

  assign sdata_out      = r_sdata_out;
  assign gpio_out       = 32'(r_op_count);
  assign gpio_in_s_insp = r_gpio_in;
  assign o_dbg_state    = r_state;

endmodule
